// File: rtl/run_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : run_monitor_pkg
// Purpose  : Shared types and constants for the run_monitor block: the run
//            controller state encoding, default sequencing constants and a
//            helper giving the width of one trace entry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package run_monitor_pkg;

    // Run controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Default sequencing constants.
    localparam int unsigned c_DEF_RST_CYCLES    = 4;
    localparam int unsigned c_DEF_STABLE_CYCLES = 8;
    localparam int unsigned c_DEF_TIMEOUT       = 10000;

    // One trace entry holds the change mask followed by one channel value.
    function automatic int unsigned trace_entry_w(input int unsigned nch,
                                                  input int unsigned data_w);
        return nch + data_w;
    endfunction

endpackage : run_monitor_pkg
`default_nettype wire

// File: rtl/run_monitor_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : run_monitor_trace_buf
// Purpose  : Linear trace log of {change mask, value} entries. The write
//            pointer is the entry count; once full, further writes are
//            dropped (no wrap). Read is combinational and returns zero for
//            indices at or beyond the current count.
// Ports    : clk, rst        - clock / synchronous active-high reset
//            clr_i           - synchronous clear of the log
//            wr_en_i         - write request (ignored when full)
//            wr_mask_i/_data_i - entry contents
//            full_o, count_o - log status
//            rd_idx_i        - read address
//            rd_mask_o/_data_o - entry at rd_idx_i (zero if not stored)
// Revision : 1.0 - initial release
// ============================================================================
module run_monitor_trace_buf
    import run_monitor_pkg::*;
#(
    parameter int unsigned NCH    = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      wr_en_i,
    input  logic [NCH-1:0]            wr_mask_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    count_o,
    input  logic [$clog2(DEPTH)-1:0]  rd_idx_i,
    output logic [NCH-1:0]            rd_mask_o,
    output logic [DATA_W-1:0]         rd_data_o
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_IDX_W + 1;
    localparam int unsigned c_ENT_W = trace_entry_w(NCH, DATA_W);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [c_ENT_W-1:0] mem_q [DEPTH];
    logic [c_CNT_W-1:0] count_q;
    logic               w_full;
    logic               w_do_wr;

    assign w_full  = (count_q == c_FULL);
    assign w_do_wr = wr_en_i && !w_full;
    assign full_o  = w_full;
    assign count_o = count_q;

    // Storage is not reset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[count_q[c_IDX_W-1:0]] <= {wr_mask_i, wr_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
        end else if (w_do_wr) begin
            count_q <= count_q + 1'b1;
        end
    end

    always_comb begin
        rd_mask_o = '0;
        rd_data_o = '0;
        if ({1'b0, rd_idx_i} < count_q) begin
            {rd_mask_o, rd_data_o} = mem_q[rd_idx_i];
        end
    end

endmodule : run_monitor_trace_buf
`default_nettype wire

// File: rtl/run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : run_monitor
// Purpose  : Run controller / observer for a processor under test. Holds the
//            processor in reset for RST_CYCLES, then counts run cycles, logs
//            every change on the NCH observed channels, and declares halt
//            once channel 0 has been unchanged for STABLE_CYCLES cycles (or
//            times out after TIMEOUT run cycles).
// Ports    : clk, rst          - clock / synchronous active-high reset
//            start, expect_val - launch a run, expected final ch0 value
//            obs               - packed observed channels
//            dut_rst           - reset driven to the processor
//            busy, done, pass, timed_out, overflow - run status
//            cycle_cnt         - run cycles elapsed
//            trace_count       - trace entries stored
//            rd_idx, rd_mask, rd_data - combinational trace read port
// Revision : 1.0 - initial release
// ============================================================================
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned NCH           = 2,
    parameter int unsigned TRACE_DEPTH   = 16,
    parameter int unsigned RST_CYCLES    = c_DEF_RST_CYCLES,
    parameter int unsigned STABLE_CYCLES = c_DEF_STABLE_CYCLES,
    parameter int unsigned TIMEOUT       = c_DEF_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [DATA_W-1:0]               expect_val,
    input  logic [NCH*DATA_W-1:0]           obs,
    output logic                            dut_rst,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic                            timed_out,
    output logic                            overflow,
    output logic [31:0]                     cycle_cnt,
    output logic [$clog2(TRACE_DEPTH):0]    trace_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0]  rd_idx,
    output logic [NCH-1:0]                  rd_mask,
    output logic [DATA_W-1:0]               rd_data
);

    localparam int unsigned c_RST_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned c_STB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_RST_W-1:0] c_RST_LAST     = c_RST_W'(RST_CYCLES - 1);
    localparam logic [c_STB_W-1:0] c_STABLE_LAST  = c_STB_W'(STABLE_CYCLES - 1);
    localparam logic [31:0]        c_TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_e                 state_q;
    logic                   dut_rst_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic                   timed_out_q;
    logic                   overflow_q;
    logic [31:0]            cycle_cnt_q;
    logic [31:0]            cycle_cnt_d;
    logic [c_STB_W-1:0]     stable_q;
    logic [c_STB_W-1:0]     stable_d;
    logic [c_RST_W-1:0]     rst_cnt_q;
    logic [NCH*DATA_W-1:0]  prev_q;
    logic [DATA_W-1:0]      expect_q;

    logic [NCH-1:0]         w_mask;
    logic [DATA_W-1:0]      w_first_val;
    logic [DATA_W-1:0]      w_ch0;
    logic                   w_in_run;
    logic                   w_start_ok;
    logic                   w_halt;
    logic                   w_tmo;
    logic                   w_wr_en;
    logic                   w_full;

    // Per-channel change detector against the previous cycle's sample.
    for (genvar k = 0; k < NCH; k++) begin : g_mask
        assign w_mask[k] = (obs[k*DATA_W +: DATA_W] != prev_q[k*DATA_W +: DATA_W]);
    end

    // Lowest-index changed channel supplies the logged value.
    always_comb begin
        w_first_val = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_mask[k]) begin
                w_first_val = obs[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ch0      = obs[DATA_W-1:0];
    assign w_in_run   = (state_q == RUN);
    assign w_start_ok = start && ((state_q == IDLE) || (state_q == DONE));

    // This cycle is the STABLE_CYCLES-th unchanged ch0 cycle in a row.
    assign w_halt  = w_in_run && !w_mask[0] && (stable_q == c_STABLE_LAST);
    // Halt takes priority over a coincident timeout.
    assign w_tmo   = w_in_run && (cycle_cnt_q == c_TIMEOUT_LAST) && !w_halt;
    // The halting edge logs nothing.
    assign w_wr_en = w_in_run && (|w_mask) && !w_halt;

    assign cycle_cnt_d = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    assign stable_d    = w_mask[0] ? '0 : stable_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dut_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            cycle_cnt_q <= '0;
            stable_q    <= '0;
            rst_cnt_q   <= '0;
            prev_q      <= '0;
            expect_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        state_q     <= RESET;
                        dut_rst_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        timed_out_q <= 1'b0;
                        overflow_q  <= 1'b0;
                        cycle_cnt_q <= '0;
                        stable_q    <= '0;
                        rst_cnt_q   <= '0;
                        expect_q    <= expect_val;
                    end
                end
                RESET: begin
                    prev_q <= obs;
                    if (rst_cnt_q == c_RST_LAST) begin
                        state_q   <= RUN;
                        dut_rst_q <= 1'b0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    prev_q      <= obs;
                    cycle_cnt_q <= cycle_cnt_d;
                    stable_q    <= stable_d;
                    if (w_wr_en && w_full) begin
                        overflow_q <= 1'b1;
                    end
                    if (w_halt) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= (w_ch0 == expect_q);
                        timed_out_q <= 1'b0;
                    end else if (w_tmo) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        timed_out_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    run_monitor_trace_buf #(
        .NCH    (NCH),
        .DATA_W (DATA_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace_buf (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (w_start_ok),
        .wr_en_i   (w_wr_en),
        .wr_mask_i (w_mask),
        .wr_data_i (w_first_val),
        .full_o    (w_full),
        .count_o   (trace_count),
        .rd_idx_i  (rd_idx),
        .rd_mask_o (rd_mask),
        .rd_data_o (rd_data)
    );

    assign dut_rst   = dut_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timed_out = timed_out_q;
    assign overflow  = overflow_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule : run_monitor
`default_nettype wire

// File: tb/tb_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_monitor
// Purpose  : Self-checking bench for run_monitor. Each run drives a channel
//            pattern per RUN cycle; a small reference model predicts trace
//            entries (queued), counters and the halt/timeout outcome.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_monitor;

    localparam int DW = 32;
    localparam int NC = 2;
    localparam int TD = 16;
    localparam int RC = 4;
    localparam int SC = 8;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] expect_val = '0;
    logic [NC*DW-1:0] obs = '0;
    logic          dut_rst;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timed_out;
    logic          overflow;
    logic [31:0]   cycle_cnt;
    logic [4:0]    trace_count;
    logic [3:0]    rd_idx = '0;
    logic [NC-1:0] rd_mask;
    logic [DW-1:0] rd_data;

    typedef struct packed {
        logic [1:0]  m;
        logic [31:0] d;
    } ent_t;

    ent_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    run_monitor #(
        .DATA_W        (DW),
        .NCH           (NC),
        .TRACE_DEPTH   (TD),
        .RST_CYCLES    (RC),
        .STABLE_CYCLES (SC),
        .TIMEOUT       (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .expect_val  (expect_val),
        .obs         (obs),
        .dut_rst     (dut_rst),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timed_out   (timed_out),
        .overflow    (overflow),
        .cycle_cnt   (cycle_cnt),
        .trace_count (trace_count),
        .rd_idx      (rd_idx),
        .rd_mask     (rd_mask),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel values for RUN cycle c of each scenario.
    function automatic logic [63:0] obs_at(input int kind, input int c);
        logic [31:0] c0;
        logic [31:0] c1;
        c0 = '0;
        c1 = '0;
        case (kind)
            0: c0 = (c < 2) ? 32'd0 : (c < 5) ? 32'd1 : (c < 9) ? 32'd2 : 32'd3;
            1: c0 = 32'((c + 1) & 1);
            2: begin
                c0 = (c < 3) ? 32'd0 : 32'h55;
                c1 = (c < 3) ? 32'd0 : (c < 6) ? 32'hAA : 32'h1234;
            end
            default: c0 = (c <= 11) ? 32'(c) : 32'd11;
        endcase
        return {c1, c0};
    endfunction

    task automatic do_run(input int kind, input logic [31:0] expv, input string name);
        int          stable;
        int          cnt;
        int          last_c;
        bit          ovf;
        bit          ended;
        bit          halt;
        bit          tmo;
        bit          exp_pass;
        logic [63:0] prev;
        logic [63:0] v;
        logic [1:0]  m;
        ent_t        e;
        stable = 0;
        cnt = 0;
        last_c = 0;
        ovf = 0;
        ended = 0;
        halt = 0;
        tmo = 0;
        exp_pass = 0;
        obs = '0;
        prev = '0;
        expect_val = expv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val({name, ".busy0"}, 64'(busy), 64'(1));
        check_val({name, ".dutrst0"}, 64'(dut_rst), 64'(1));
        check_val({name, ".cnt_clr"}, 64'(trace_count), 64'(0));
        for (int i = 1; i < RC; i++) begin
            tick();
            check_val({name, ".dutrst"}, 64'(dut_rst), 64'(1));
        end
        tick();
        check_val({name, ".run_rst"}, 64'(dut_rst), 64'(0));
        check_val({name, ".cyc0"}, 64'(cycle_cnt), 64'(0));
        for (int c = 0; c < TO + 4 && !ended; c++) begin
            v = obs_at(kind, c);
            obs = v;
            start = (kind == 0 && c == 4);
            m = {v[63:32] != prev[63:32], v[31:0] != prev[31:0]};
            prev = v;
            halt = !m[0] && (stable == SC - 1);
            tmo = !halt && (c == TO - 1);
            if (m != 2'b00 && !halt) begin
                if (cnt < TD) begin
                    exp_q.push_back({m, m[0] ? v[31:0] : v[63:32]});
                    cnt++;
                end else begin
                    ovf = 1;
                end
            end
            stable = m[0] ? 0 : stable + 1;
            ended = halt || tmo;
            exp_pass = halt && (v[31:0] == expv);
            last_c = c;
            tick();
            start = 1'b0;
            check_val({name, ".cyc"}, 64'(cycle_cnt), 64'(c + 1));
            check_val({name, ".tcnt"}, 64'(trace_count), 64'(cnt));
            check_val({name, ".done"}, 64'(done), 64'(ended));
            check_val({name, ".ovf"}, 64'(overflow), 64'(ovf));
        end
        check_val({name, ".ended"}, 64'(ended), 64'(1));
        check_val({name, ".pass"}, 64'(pass), 64'(exp_pass));
        check_val({name, ".tmo"}, 64'(timed_out), 64'(tmo));
        check_val({name, ".busy"}, 64'(busy), 64'(0));
        check_val({name, ".dutrst_done"}, 64'(dut_rst), 64'(0));
        // Outputs stay frozen while the channels keep moving.
        obs = ~obs;
        tick();
        obs = ~obs;
        tick();
        check_val({name, ".frz_cyc"}, 64'(cycle_cnt), 64'(last_c + 1));
        check_val({name, ".frz_cnt"}, 64'(trace_count), 64'(cnt));
        check_val({name, ".frz_done"}, 64'(done), 64'(1));
        for (int i = 0; i < cnt; i++) begin
            rd_idx = 4'(i);
            #1;
            e = exp_q.pop_front();
            check_val({name, ".rmask"}, 64'(rd_mask), 64'(e.m));
            check_val({name, ".rdata"}, 64'(rd_data), 64'(e.d));
        end
        if (cnt < TD) begin
            rd_idx = 4'(cnt);
            #1;
            check_val({name, ".rmask_oob"}, 64'(rd_mask), 64'(0));
            check_val({name, ".rdata_oob"}, 64'(rd_data), 64'(0));
        end
        rd_idx = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check_val("rst.dutrst", 64'(dut_rst), 64'(1));
        check_val("rst.busy", 64'(busy), 64'(0));
        check_val("rst.done", 64'(done), 64'(0));
        check_val("rst.pass", 64'(pass), 64'(0));
        check_val("rst.tmo", 64'(timed_out), 64'(0));
        check_val("rst.ovf", 64'(overflow), 64'(0));
        check_val("rst.cyc", 64'(cycle_cnt), 64'(0));
        check_val("rst.tcnt", 64'(trace_count), 64'(0));
        rst = 1'b0;
        tick();
        check_val("idle.dutrst", 64'(dut_rst), 64'(1));

        do_run(0, 32'd3, "pass");
        check_val("pass.final_cyc", 64'(cycle_cnt), 64'(18));
        check_val("pass.final_pass", 64'(pass), 64'(1));

        do_run(2, 32'h56, "multi");
        check_val("multi.final_pass", 64'(pass), 64'(0));

        do_run(1, 32'd0, "tmo");
        check_val("tmo.final_tcnt", 64'(trace_count), 64'(16));
        check_val("tmo.final_ovf", 64'(overflow), 64'(1));
        check_val("tmo.final_tmo", 64'(timed_out), 64'(1));

        do_run(3, 32'd11, "coin");
        check_val("coin.final_pass", 64'(pass), 64'(1));
        check_val("coin.final_tmo", 64'(timed_out), 64'(0));
        check_val("coin.final_cyc", 64'(cycle_cnt), 64'(TO));

        // Reset in the middle of a run.
        obs = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RC) tick();
        for (int c = 0; c < 5; c++) begin
            obs = obs_at(1, c);
            tick();
        end
        check_val("mid.tcnt_pre", 64'(trace_count), 64'(5));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid.dutrst", 64'(dut_rst), 64'(1));
        check_val("mid.busy", 64'(busy), 64'(0));
        check_val("mid.tcnt", 64'(trace_count), 64'(0));
        check_val("mid.cyc", 64'(cycle_cnt), 64'(0));
        tick();
        do_run(0, 32'd3, "again");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_run_monitor
`default_nettype wire
